// File: rtl/csi2_tx_packetizer.sv
// -----------------------------------------------------------------------------
// csi2_tx_packetizer
//
// Purpose:
//   Wraps a packed RAW10 payload word stream into CSI-2 packets. Each input
//   frame becomes a Frame Start short packet, FRAME_LINES long packets
//   (header with ECC, LINE_BYTES of payload, CRC-16 word) and a Frame End
//   short packet. Payload words pass straight through with zero latency, and
//   all other words are decoded from FSM registers. Input lines that are too
//   short are zero-padded. Input lines that are too long are truncated. A
//   tuser that arrives mid-frame closes the current frame and starts a new one.
//
// Ports:
//   clk_i           single clock
//   rst_i           asynchronous assert, active-high reset
//   pkt_i_*         AXI4-Stream slave, payload words. First byte is in
//                   tdata[7:0]. tuser = first word of frame, tlast = last
//                   word of line.
//   pkt_o_*         AXI4-Stream master, CSI-2 words in the same byte order.
//                   tstrb marks valid bytes. tlast = last word of each packet.
//   line_len_err_o  one-cycle pulse on an input handshake that shows the
//                   line length differs from LINE_BYTES
//   sync_err_o      one-cycle pulse when tuser arrives inside a frame
// -----------------------------------------------------------------------------
module csi2_tx_packetizer #(
  parameter logic [7:0] DATA_TYPE   = 8'h2B,
  parameter int         LINE_BYTES  = 2400,
  parameter int         FRAME_LINES = 1080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pkt_i_tdata,
  input  logic        pkt_i_tvalid,
  output logic        pkt_i_tready,
  input  logic        pkt_i_tuser,
  input  logic        pkt_i_tlast,
  output logic [31:0] pkt_o_tdata,
  output logic [3:0]  pkt_o_tstrb,
  output logic        pkt_o_tvalid,
  input  logic        pkt_o_tready,
  output logic        pkt_o_tlast,
  output logic        line_len_err_o,
  output logic        sync_err_o
);

  localparam int WORDS = LINE_BYTES / 4;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LCW   = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
  localparam logic [LCW-1:0] LAST_LINE = LCW'(FRAME_LINES - 1);

  // Short packets always carry WC = 0 (frame number 0), so both words are
  // fixed. The FE ECC over data 24'h000001 is 6'h07.
  localparam logic [31:0] FS_WORD = 32'h0000_0000;
  localparam logic [31:0] FE_WORD = 32'h0700_0001;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FS      = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PAD     = 3'd4;
  localparam logic [2:0] S_DROP    = 3'd5;
  localparam logic [2:0] S_CRC     = 3'd6;
  localparam logic [2:0] S_FE      = 3'd7;

  // Each ECC bit is the XOR of the header data bits selected by its row of
  // this parity matrix. Row gi produces ECC bit gi.
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00,  // P5
    24'hDF03F0,  // P4
    24'hB8E38E,  // P3
    24'h749A6D,  // P2
    24'hF2555B,  // P1
    24'hF12CB7   // P0
  };

  // ---------------------------------------------------------------------------
  // Long packet header (constant for a given parameter set)
  // ---------------------------------------------------------------------------
  logic [23:0] hdr_data;
  logic [5:0]  hdr_ecc;
  logic [31:0] hdr_word;

  assign hdr_data = {16'(LINE_BYTES), DATA_TYPE};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_ecc
      assign hdr_ecc[gi] = ^(hdr_data & ECC_MASK[gi]);
    end
  endgenerate

  assign hdr_word = {2'b00, hdr_ecc, hdr_data};

  // ---------------------------------------------------------------------------
  // CRC-16 (reflected 0x8408). The 32 bits are taken in byte order, LSB first,
  // which is simply ascending bit index of the packed word.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                             input logic [31:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int b = 0; b < 32; b++) begin
      if (c[0] ^ data[b]) begin
        c = (c >> 1) ^ 16'h8408;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]     state_reg,    state_next;
  logic [WCW-1:0] word_cnt_reg, word_cnt_next;
  logic [LCW-1:0] line_cnt_reg, line_cnt_next;
  logic [15:0]    crc_reg,      crc_next;
  logic           in_frame_reg, in_frame_next;
  logic           restart_reg,  restart_next;

  logic        in_ready;
  logic        in_hs;
  logic        out_hs;
  logic        last_word;
  logic [15:0] crc_upd;

  assign last_word = (word_cnt_reg == LAST_WORD);
  assign in_hs     = pkt_i_tvalid && pkt_i_tready;
  assign out_hs    = pkt_o_tvalid && pkt_o_tready;

  // PAD feeds zeros into the CRC, while PAYLOAD feeds the live input word.
  assign crc_upd = crc16_word(crc_reg,
                              (state_reg == S_PAYLOAD) ? pkt_i_tdata : 32'h0);

  // ---------------------------------------------------------------------------
  // Output decode. Payload is a combinational pass-through. All other words
  // depend only on registers, so they hold steady while the sink stalls.
  // ---------------------------------------------------------------------------
  always_comb begin
    pkt_o_tdata    = 32'h0;
    pkt_o_tstrb    = 4'h0;
    pkt_o_tvalid   = 1'b0;
    pkt_o_tlast    = 1'b0;
    in_ready       = 1'b0;
    line_len_err_o = 1'b0;
    sync_err_o     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // Stray words outside a frame are swallowed. A tuser word waits here
        // and is consumed later as the first payload word.
        in_ready   = pkt_i_tvalid && !pkt_i_tuser && !in_frame_reg;
        sync_err_o = pkt_i_tvalid && pkt_i_tuser && in_frame_reg;
      end
      S_FS: begin
        pkt_o_tvalid = 1'b1;
        pkt_o_tdata  = FS_WORD;
        pkt_o_tstrb  = 4'hF;
        pkt_o_tlast  = 1'b1;
      end
      S_HDR: begin
        pkt_o_tvalid = 1'b1;
        pkt_o_tdata  = hdr_word;
        pkt_o_tstrb  = 4'hF;
      end
      S_PAYLOAD: begin
        pkt_o_tvalid = pkt_i_tvalid;
        pkt_o_tdata  = pkt_i_tdata;
        pkt_o_tstrb  = 4'hF;
        in_ready     = pkt_o_tready;
        // Either tlast arrived early or it is missing on the final word.
        line_len_err_o = pkt_i_tvalid && pkt_o_tready && (pkt_i_tlast != last_word);
      end
      S_PAD: begin
        pkt_o_tvalid = 1'b1;
        pkt_o_tstrb  = 4'hF;
      end
      S_DROP: begin
        in_ready = 1'b1;
      end
      S_CRC: begin
        pkt_o_tvalid = 1'b1;
        pkt_o_tdata  = {16'h0, crc_reg};
        pkt_o_tstrb  = 4'b0011;
        pkt_o_tlast  = 1'b1;
      end
      S_FE: begin
        pkt_o_tvalid = 1'b1;
        pkt_o_tdata  = FE_WORD;
        pkt_o_tstrb  = 4'hF;
        pkt_o_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  // Keep tready low for the whole reset, even if the source keeps tvalid high.
  assign pkt_i_tready = in_ready && !rst_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    line_cnt_next = line_cnt_reg;
    crc_next      = crc_reg;
    in_frame_next = in_frame_reg;
    restart_next  = restart_reg;
    case (state_reg)
      S_IDLE: begin
        if (pkt_i_tvalid) begin
          if (pkt_i_tuser && !in_frame_reg) begin
            state_next = S_FS;
          end else if (pkt_i_tuser && in_frame_reg) begin
            state_next   = S_FE;
            restart_next = 1'b1;
          end else if (in_frame_reg) begin
            state_next = S_HDR;
          end
        end
      end
      S_FS: begin
        if (out_hs) begin
          in_frame_next = 1'b1;
          line_cnt_next = '0;
          state_next    = S_HDR;
        end
      end
      S_HDR: begin
        if (out_hs) begin
          word_cnt_next = '0;
          crc_next      = 16'hFFFF;
          state_next    = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (in_hs) begin
          crc_next = crc_upd;
          if (last_word) begin
            state_next = pkt_i_tlast ? S_CRC : S_DROP;
          end else begin
            word_cnt_next = word_cnt_reg + 1'b1;
            if (pkt_i_tlast) begin
              state_next = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        if (out_hs) begin
          crc_next = crc_upd;
          if (last_word) begin
            state_next = S_CRC;
          end else begin
            word_cnt_next = word_cnt_reg + 1'b1;
          end
        end
      end
      S_DROP: begin
        if (in_hs && pkt_i_tlast) begin
          state_next = S_CRC;
        end
      end
      S_CRC: begin
        if (out_hs) begin
          if (line_cnt_reg == LAST_LINE) begin
            line_cnt_next = '0;
            state_next    = S_FE;
          end else begin
            line_cnt_next = line_cnt_reg + 1'b1;
            state_next    = S_IDLE;
          end
        end
      end
      S_FE: begin
        if (out_hs) begin
          in_frame_next = 1'b0;
          if (restart_reg) begin
            restart_next = 1'b0;
            state_next   = S_FS;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= S_IDLE;
      word_cnt_reg <= '0;
      line_cnt_reg <= '0;
      crc_reg      <= 16'hFFFF;
      in_frame_reg <= 1'b0;
      restart_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      line_cnt_reg <= line_cnt_next;
      crc_reg      <= crc_next;
      in_frame_reg <= in_frame_next;
      restart_reg  <= restart_next;
    end
  end

endmodule

// File: tb/tb_csi2_tx_packetizer.sv
// -----------------------------------------------------------------------------
// tb_csi2_tx_packetizer
//
// Drives randomized frames (with random valid gaps and sink backpressure) into
// csi2_tx_packetizer. It collects every output handshake and compares the
// collected words with a packet-level reference model of the CSI-2 framing
// rules. The bench also covers reset values, the fixed reference vector,
// short/long lines, a mid-frame tuser, and an asynchronous reset mid-payload.
// -----------------------------------------------------------------------------
module tb_csi2_tx_packetizer;

  localparam int LINE_BYTES  = 24;
  localparam int FRAME_LINES = 2;
  localparam int WPL         = LINE_BYTES / 4;

  localparam logic [31:0] HDR_WORD = 32'h1400182B;
  localparam logic [31:0] FE_WORD  = 32'h07000001;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic        in_tuser = 1'b0;
  logic        in_tlast = 1'b0;
  logic [31:0] out_tdata;
  logic [3:0]  out_tstrb;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic        out_tlast;
  logic        line_len_err;
  logic        sync_err;

  always #5 clk_i = ~clk_i;

  csi2_tx_packetizer #(
    .DATA_TYPE  (8'h2B),
    .LINE_BYTES (LINE_BYTES),
    .FRAME_LINES(FRAME_LINES)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pkt_i_tdata    (in_tdata),
    .pkt_i_tvalid   (in_tvalid),
    .pkt_i_tready   (in_tready),
    .pkt_i_tuser    (in_tuser),
    .pkt_i_tlast    (in_tlast),
    .pkt_o_tdata    (out_tdata),
    .pkt_o_tstrb    (out_tstrb),
    .pkt_o_tvalid   (out_tvalid),
    .pkt_o_tready   (out_tready),
    .pkt_o_tlast    (out_tlast),
    .line_len_err_o (line_len_err),
    .sync_err_o     (sync_err)
  );

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } in_word_t;

  in_word_t    src_q[$];
  logic [36:0] got_q[$];   // {tlast, tstrb, tdata}
  logic [36:0] exp_q[$];
  int          got_lerr, got_serr, exp_lerr, exp_serr;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] crc_tab [256];

  logic [31:0] spec_line [WPL] = '{32'h020000FF, 32'h72F3DCB9, 32'h5AB8D4BB,
                                   32'h7CC275C8, 32'hDF05F881, 32'h010000FF};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: walks the queued input words line by line and builds the
  // packet words the framing rules call for. The CRC is table-driven.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] crc_bytes(input logic [15:0] crc, input logic [31:0] w);
    logic [15:0] c;
    c = crc;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] byte_v;
      byte_v = w[8*k +: 8];
      c = (c >> 8) ^ crc_tab[c[7:0] ^ byte_v];
    end
    return c;
  endfunction

  task automatic model();
    int          i;
    int          n;
    int          line;
    bit          in_frame;
    logic [15:0] crc;
    logic [31:0] w;
    i = 0; line = 0; in_frame = 0;
    exp_q.delete();
    exp_lerr = 0;
    exp_serr = 0;
    while (i < src_q.size()) begin
      if (!in_frame) begin
        if (!src_q[i].user) begin
          i++;
          continue;
        end
        exp_q.push_back({1'b1, 4'hF, 32'h0});
        in_frame = 1;
        line = 0;
      end else if (src_q[i].user) begin
        exp_serr++;
        exp_q.push_back({1'b1, 4'hF, FE_WORD});
        exp_q.push_back({1'b1, 4'hF, 32'h0});
        line = 0;
      end
      exp_q.push_back({1'b0, 4'hF, HDR_WORD});
      n = 1;
      while ((i + n - 1) < src_q.size() && !src_q[i + n - 1].last) n++;
      if (n != WPL) exp_lerr++;
      crc = 16'hFFFF;
      for (int k = 0; k < WPL; k++) begin
        w = (k < n) ? src_q[i + k].data : 32'h0;
        exp_q.push_back({1'b0, 4'hF, w});
        crc = crc_bytes(crc, w);
      end
      exp_q.push_back({1'b1, 4'b0011, 16'h0, crc});
      i += n;
      line++;
      if (line == FRAME_LINES) begin
        exp_q.push_back({1'b1, 4'hF, FE_WORD});
        in_frame = 0;
        line = 0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic add_line(input bit first, input int nwords);
    for (int k = 0; k < nwords; k++) begin
      src_q.push_back({first && (k == 0), k == nwords - 1, 32'($urandom)});
    end
  endtask

  task automatic add_spec_line(input bit first);
    for (int k = 0; k < WPL; k++) begin
      src_q.push_back({first && (k == 0), k == WPL - 1, spec_line[k]});
    end
  endtask

  // Drives the input queue and collects output handshakes. All driving happens
  // on the falling edge, and sampling happens 1 ns later, well before the
  // rising edge. abort_after > 0 returns early (used for the reset test).
  task automatic run(input int rdy_pct, input int vld_pct, input int abort_after);
    int          cyc;
    int          tail;
    bit          hold;
    bit          prev_stall;
    logic [37:0] prev_word;
    cyc = 0; tail = 0; hold = 0; prev_stall = 0; prev_word = '0;
    got_q.delete();
    got_lerr = 0;
    got_serr = 0;
    while (1) begin
      @(negedge clk_i);
      if (!hold) begin
        if (src_q.size() > 0 && int'($urandom_range(99)) < vld_pct) begin
          in_tvalid = 1'b1;
          {in_tuser, in_tlast, in_tdata} = src_q[0];
        end else begin
          in_tvalid = 1'b0;
          in_tuser  = 1'b0;
          in_tlast  = 1'b0;
          in_tdata  = $urandom;
        end
      end
      out_tready = (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (prev_stall)
        chk("stall_hold", 64'({out_tvalid, out_tlast, out_tstrb, out_tdata}), 64'(prev_word));
      if (out_tvalid && out_tready) got_q.push_back({out_tlast, out_tstrb, out_tdata});
      if (line_len_err) got_lerr++;
      if (sync_err) got_serr++;
      if (in_tvalid && in_tready) begin
        void'(src_q.pop_front());
        hold = 0;
      end else begin
        hold = in_tvalid;
      end
      prev_stall = out_tvalid && !out_tready;
      prev_word  = {out_tvalid, out_tlast, out_tstrb, out_tdata};
      cyc++;
      if (abort_after > 0 && cyc >= abort_after) return;
      if (src_q.size() == 0) tail++;
      if (tail >= 60) break;
      if (cyc >= 5000) begin
        chk("timeout_src_left", 64'(src_q.size()), 64'(0));
        break;
      end
    end
    in_tvalid = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    int m;
    chk($sformatf("%s_nwords", tag), 64'(got_q.size()), 64'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < m; k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
    chk($sformatf("%s_line_len_err", tag), 64'(got_lerr), 64'(exp_lerr));
    chk($sformatf("%s_sync_err", tag), 64'(got_serr), 64'(exp_serr));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(out_tvalid), 64'(0));
    chk({tag, "_tdata"},  64'(out_tdata),  64'(0));
    chk({tag, "_tstrb"},  64'(out_tstrb),  64'(0));
    chk({tag, "_tlast"},  64'(out_tlast),  64'(0));
    chk({tag, "_tready"}, 64'(in_tready),  64'(0));
    chk({tag, "_lerr"},   64'(line_len_err), 64'(0));
    chk({tag, "_serr"},   64'(sync_err),   64'(0));
  endtask

  initial begin
    for (int b = 0; b < 256; b++) begin
      logic [15:0] c;
      c = 16'(b);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      crc_tab[b] = c;
    end

    // Reset state, during reset and after release
    @(negedge clk_i); #1;
    check_idle_outputs("in_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    check_idle_outputs("after_reset");

    // Reference vector, sink always ready
    add_spec_line(1'b1);
    add_spec_line(1'b0);
    model();
    run(100, 100, 0);
    compare_all("spec");
    if (got_q.size() >= 18) begin
      chk("spec_fs",  64'(got_q[0]),  64'({1'b1, 4'hF, 32'h00000000}));
      chk("spec_hdr", 64'(got_q[1]),  64'({1'b0, 4'hF, 32'h1400182B}));
      chk("spec_crc", 64'(got_q[8]),  64'({1'b1, 4'h3, 32'h000000F0}));
      chk("spec_fe",  64'(got_q[17]), 64'({1'b1, 4'hF, 32'h07000001}));
    end

    // Reference vector under 50% backpressure and input gaps
    add_spec_line(1'b1);
    add_spec_line(1'b0);
    model();
    run(50, 70, 0);
    compare_all("spec_bp");

    // Short line (4 words), then a normal line
    add_line(1'b1, 4);
    add_line(1'b0, WPL);
    model();
    run(100, 100, 0);
    compare_all("short");

    // Long line (8 words), then a normal line
    add_line(1'b1, 8);
    add_line(1'b0, WPL);
    model();
    run(60, 80, 0);
    compare_all("long");

    // tuser on line 1 of a 2-line frame, with stray words outside the frame first
    add_line(1'b0, 3);
    add_line(1'b1, WPL);
    add_line(1'b1, WPL);
    add_line(1'b0, WPL);
    model();
    run(100, 100, 0);
    compare_all("sync");

    // Randomized frames
    for (int r = 0; r < 5; r++) begin
      for (int f = 0; f < 2; f++) begin
        add_line(1'b1, int'($urandom_range(1, 9)));
        add_line(($urandom_range(7) == 0), int'($urandom_range(1, 9)));
      end
      model();
      run(int'($urandom_range(30, 100)), int'($urandom_range(50, 100)), 0);
      compare_all($sformatf("rand%0d", r));
    end

    // Asynchronous reset mid-payload
    add_spec_line(1'b1);
    add_spec_line(1'b0);
    run(100, 100, 5);
    @(posedge clk_i); #2;
    chk("pre_rst_payload_valid", 64'(out_tvalid), 64'(1));
    rst_i = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    src_q.delete();
    in_tvalid = 1'b0;
    add_spec_line(1'b1);
    add_line(1'b0, WPL);
    model();
    run(50, 70, 0);
    compare_all("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
